// File: rtl/bnn_feature_loader.sv
// Front end of a sequential BNN core: quantizes raw beats, packs a frame, starts the core,
// then hands its prediction downstream. Define FEAT_ROUND_EN for round-half-up quantization.
module bnn_feature_loader #(
  parameter  int FEAT_CNT    = 11,
  parameter  int FEAT_BITS   = 4,
  parameter  int RAW_BITS    = 8,
  parameter  int CLASS_CNT   = 6,
  parameter  int HOLD_CYCLES = 48,
  localparam int PRED_W      = (CLASS_CNT > 1) ? $clog2(CLASS_CNT) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [RAW_BITS-1:0]           in_data,
  input  logic                          in_last,
  output logic [FEAT_CNT*FEAT_BITS-1:0] features,
  output logic                          bnn_start,
  input  logic [PRED_W-1:0]             prediction,
  output logic                          pred_valid,
  input  logic                          pred_ready,
  output logic [PRED_W-1:0]             pred_out,
  output logic                          frame_err
);

  localparam int IDX_W  = (FEAT_CNT > 1) ? $clog2(FEAT_CNT) : 1;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(FEAT_CNT - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_RUN    = 2'd1,
    S_RESULT = 2'd2
  } state_t;

  state_t                             r_state;
  logic [IDX_W-1:0]                   r_idx;
  logic [HOLD_W-1:0]                  r_hold;
  logic [FEAT_CNT-1:0][FEAT_BITS-1:0] r_features;
  logic                               r_in_ready;
  logic                               r_bnn_start;
  logic                               r_pred_valid;
  logic [PRED_W-1:0]                  r_pred_out;
  logic                               r_frame_err;

  logic [FEAT_BITS-1:0] w_q;
  logic                 w_unused_raw;
  logic                 w_last_idx;

  // Low raw bits only feed the rounding variant; fold them so they are not left dangling.
  assign w_unused_raw = ^in_data;
  assign w_last_idx   = (r_idx == LAST_IDX);

`ifdef FEAT_ROUND_EN
  if (RAW_BITS > FEAT_BITS) begin : g_round
    logic [FEAT_BITS:0] w_sum;
    assign w_sum = {1'b0, in_data[RAW_BITS-1 -: FEAT_BITS]}
                 + (FEAT_BITS+1)'(in_data[RAW_BITS-FEAT_BITS-1]);
    // The extra sum bit flags overflow; clamp to all-ones instead of wrapping.
    assign w_q = w_sum[FEAT_BITS] ? '1 : w_sum[FEAT_BITS-1:0];
  end else begin : g_pass
    assign w_q = in_data[RAW_BITS-1 -: FEAT_BITS];
  end
`else
  assign w_q = in_data[RAW_BITS-1 -: FEAT_BITS];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_LOAD;
      r_idx        <= '0;
      r_hold       <= '0;
      r_features   <= '0;
      r_in_ready   <= 1'b0;
      r_bnn_start  <= 1'b0;
      r_pred_valid <= 1'b0;
      r_pred_out   <= '0;
      r_frame_err  <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low each cycle; only the branch that fires them sets them.
      r_bnn_start <= 1'b0;
      r_frame_err <= 1'b0;
      unique case (r_state)
        S_LOAD: begin
          r_in_ready <= 1'b1;
          if (in_valid && r_in_ready) begin
            if (w_last_idx && in_last) begin
              r_features[r_idx] <= w_q;
              r_idx             <= '0;
              r_in_ready        <= 1'b0;
              r_bnn_start       <= 1'b1;
              r_state           <= S_RUN;
            end else if (w_last_idx || in_last) begin
              r_frame_err <= 1'b1;
              r_idx       <= '0;
            end else begin
              r_features[r_idx] <= w_q;
              r_idx             <= r_idx + IDX_W'(1);
            end
          end
        end
        S_RUN: begin
          // The start cycle itself arms the counter, so sampling lands HOLD_CYCLES later.
          if (r_bnn_start) begin
            r_hold <= HOLD_LOAD;
          end else if (r_hold == '0) begin
            r_pred_out   <= prediction;
            r_pred_valid <= 1'b1;
            r_state      <= S_RESULT;
          end else begin
            r_hold <= r_hold - HOLD_W'(1);
          end
        end
        S_RESULT: begin
          if (pred_ready) begin
            r_pred_valid <= 1'b0;
            r_in_ready   <= 1'b1;
            r_state      <= S_LOAD;
          end
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign features   = r_features;
  assign bnn_start  = r_bnn_start;
  assign pred_valid = r_pred_valid;
  assign pred_out   = r_pred_out;
  assign frame_err  = r_frame_err;

endmodule
